// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and constants for the memory-stage load/store unit
package mem_lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      DONE
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } lsu_size_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Reserved funct3 codes fall through to word access.
   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - AXI4-Lite data-port channels with master/slave views
interface mem_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   AWADDR;
   logic                AWVALID;
   logic                AWREADY;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WVALID;
   logic                WREADY;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;
   logic [ADDR_W-1:0]   ARADDR;
   logic                ARVALID;
   logic                ARREADY;
   logic [DATA_W-1:0]   RDATA;
   logic [1:0]          RRESP;
   logic                RVALID;
   logic                RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - store lane shift/strobes, misalign detect, load extract/extend
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_data,
   output logic [3:0]  st_strb,
   output logic        st_misaligned,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);
   lsu_size_e   st_sz;
   logic [31:0] ld_sh;

   always_comb begin
      st_sz   = f3_size(st_funct3);
      st_data = st_wdata << {st_addr_lo, 3'b000};
      case (st_sz)
         SZ_B: begin
            st_strb       = 4'b0001 << st_addr_lo;
            st_misaligned = 1'b0;
         end
         SZ_H: begin
            st_strb       = 4'b0011 << st_addr_lo;
            st_misaligned = st_addr_lo[0];
         end
         default: begin
            st_strb       = 4'b1111;
            st_misaligned = (st_addr_lo != 2'b00);
         end
      endcase
   end

   // Selected byte/half is brought down to lane 0 before extension.
   always_comb begin
      ld_sh = ld_rdata >> {ld_addr_lo, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
         F3_BU:   ld_data = {24'h0, ld_sh[7:0]};
         F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
         F3_HU:   ld_data = {16'h0, ld_sh[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end
endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: one AXI4-Lite transaction per op, stalls pipeline
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall_req,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              misalign_err,
   output logic              bus_err,
   mem_lsu_if.master         axi
);
   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic              mis_q;
   logic              err_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        strb_q;
   logic              aw_done_q, w_done_q;
   logic [DATA_W-1:0] load_data_q;

   logic [DATA_W-1:0] st_data;
   logic [3:0]        st_strb;
   logic              st_misaligned;
   logic [DATA_W-1:0] ld_data;
   logic              accept;

   lsu_align u_align (
      .st_funct3     (req_funct3),
      .st_addr_lo    (req_addr[1:0]),
      .st_wdata      (req_wdata),
      .st_data       (st_data),
      .st_strb       (st_strb),
      .st_misaligned (st_misaligned),
      .ld_funct3     (funct3_q),
      .ld_addr_lo    (addr_q[1:0]),
      .ld_rdata      (axi.RDATA),
      .ld_data       (ld_data)
   );

   assign accept = (state_q == IDLE) && req_valid;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (st_misaligned) state_d = DONE;
               else if (req_we)   state_d = WR_REQ;
               else               state_d = RD_ADDR;
            end
         end
         RD_ADDR: if (axi.ARREADY) state_d = RD_DATA;
         RD_DATA: if (axi.RVALID)  state_d = DONE;
         // AW and W may complete in either order or together.
         WR_REQ: begin
            if ((aw_done_q || axi.AWREADY) && (w_done_q || axi.WREADY))
               state_d = WR_RESP;
         end
         WR_RESP: if (axi.BVALID) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q      <= '0;
         funct3_q    <= '0;
         we_q        <= 1'b0;
         mis_q       <= 1'b0;
         err_q       <= 1'b0;
         wdata_q     <= '0;
         strb_q      <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         load_data_q <= '0;
      end else begin
         if (accept) begin
            addr_q    <= req_addr;
            funct3_q  <= req_funct3;
            we_q      <= req_we;
            mis_q     <= st_misaligned;
            err_q     <= 1'b0;
            wdata_q   <= st_data;
            strb_q    <= st_strb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (state_q == WR_REQ) begin
            if (axi.AWVALID && axi.AWREADY) aw_done_q <= 1'b1;
            if (axi.WVALID && axi.WREADY)   w_done_q  <= 1'b1;
         end
         // Errored reads return zero so MEM/WB never sees stale bus data.
         if (state_q == RD_DATA && axi.RVALID) begin
            load_data_q <= (axi.RRESP == RESP_OKAY) ? ld_data : '0;
            err_q       <= (axi.RRESP != RESP_OKAY);
         end
         if (state_q == WR_RESP && axi.BVALID)
            err_q <= (axi.BRESP != RESP_OKAY);
      end
   end

   always_comb begin
      axi.ARVALID  = (state_q == RD_ADDR);
      axi.ARADDR   = {addr_q[ADDR_W-1:2], 2'b00};
      axi.RREADY   = (state_q == RD_DATA);
      axi.AWVALID  = (state_q == WR_REQ) && !aw_done_q;
      axi.AWADDR   = {addr_q[ADDR_W-1:2], 2'b00};
      axi.WVALID   = (state_q == WR_REQ) && !w_done_q;
      axi.WDATA    = wdata_q;
      axi.WSTRB    = strb_q;
      axi.BREADY   = (state_q == WR_RESP);
      stall_req    = req_valid && (state_q != DONE) && !((state_q == IDLE) && st_misaligned);
      misalign_err = accept && st_misaligned;
      load_valid   = (state_q == DONE) && !we_q && !mis_q;
      bus_err      = (state_q == DONE) && err_q;
      load_data    = load_data_q;
   end
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu with a configurable AXI4-Lite slave
module tb_mem_lsu;
   logic        ACLK;
   logic        ARESETn;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall_req;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misalign_err;
   logic        bus_err;

   mem_lsu_if axi ();

   mem_lsu dut (
      .ACLK         (ACLK),
      .ARESETn      (ARESETn),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall_req    (stall_req),
      .load_data    (load_data),
      .load_valid   (load_valid),
      .misalign_err (misalign_err),
      .bus_err      (bus_err),
      .axi          (axi)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Slave model: READY after N cycles of VALID, RVALID after N cycles pending.
   int          ar_wait, aw_wait, w_wait, r_wait;
   logic [31:0] rdata_cfg;
   logic [1:0]  rresp_cfg, bresp_cfg;
   int          ar_cnt, aw_cnt, w_cnt, r_cnt;
   logic        r_pend, aw_got, w_got, b_pend;
   logic        aw_now, w_now;

   assign axi.ARREADY = axi.ARVALID && (ar_cnt >= ar_wait);
   assign axi.AWREADY = axi.AWVALID && (aw_cnt >= aw_wait);
   assign axi.WREADY  = axi.WVALID && (w_cnt >= w_wait);
   assign axi.RVALID  = r_pend && (r_cnt >= r_wait);
   assign axi.RDATA   = rdata_cfg;
   assign axi.RRESP   = rresp_cfg;
   assign axi.BVALID  = b_pend;
   assign axi.BRESP   = bresp_cfg;
   assign aw_now = aw_got || (axi.AWVALID && axi.AWREADY);
   assign w_now  = w_got || (axi.WVALID && axi.WREADY);

   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
         r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      end else begin
         ar_cnt <= (axi.ARVALID && !axi.ARREADY) ? ar_cnt + 1 : 0;
         aw_cnt <= (axi.AWVALID && !axi.AWREADY) ? aw_cnt + 1 : 0;
         w_cnt  <= (axi.WVALID && !axi.WREADY) ? w_cnt + 1 : 0;
         if (axi.ARVALID && axi.ARREADY) begin
            r_pend <= 1'b1;
            r_cnt  <= 0;
         end else if (axi.RVALID && axi.RREADY) begin
            r_pend <= 1'b0;
         end else if (r_pend) begin
            r_cnt <= r_cnt + 1;
         end
         if (axi.BVALID && axi.BREADY) b_pend <= 1'b0;
         if (aw_now && w_now) begin
            b_pend <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else begin
            aw_got <= aw_now;
            w_got  <= w_now;
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Observations of one operation, k = cycles since request (k=0 is cycle N).
   int          lat, ar_first, rr_first, aw_hs, w_hs;
   logic [31:0] ar_addr, aw_addr, w_data;
   logic [3:0]  w_strb;
   logic        lv_done, be_done, mis0, post_lv, post_valid;

   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
      int k;
      lat = -1; ar_first = -1; rr_first = -1; aw_hs = -1; w_hs = -1;
      ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
      @(posedge ACLK); #1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      k = 0;
      while (lat < 0 && k < 30) begin
         @(negedge ACLK);
         if (k == 0) mis0 = misalign_err;
         if (axi.ARVALID && ar_first < 0) begin ar_first = k; ar_addr = axi.ARADDR; end
         if (axi.RREADY && rr_first < 0) rr_first = k;
         if (axi.AWVALID && axi.AWREADY) begin aw_hs = k; aw_addr = axi.AWADDR; end
         if (axi.WVALID && axi.WREADY) begin w_hs = k; w_data = axi.WDATA; w_strb = axi.WSTRB; end
         if (!stall_req) begin
            lat = k; lv_done = load_valid; be_done = bus_err;
         end else begin
            k++;
         end
      end
      if (lat < 0) chk("op_timeout", 32'(k), 32'(0));
      @(posedge ACLK); #1;
      req_valid = 1'b0;
      @(negedge ACLK);
      post_lv = load_valid;
      post_valid = axi.ARVALID | axi.AWVALID | axi.WVALID;
      repeat (2) @(posedge ACLK);
   endtask

   initial begin
      ARESETn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0;
      rdata_cfg = '0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
      repeat (2) @(negedge ACLK);
      chk("reset_outs", {23'h0, stall_req, load_valid, misalign_err, bus_err, axi.ARVALID,
                         axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY}, 32'h0);
      chk("reset_load_data", load_data, 32'h0);
      @(posedge ACLK); #1 ARESETn = 1'b1;

      // LW, zero waits
      rdata_cfg = 32'h8899AABB;
      run_op(1'b0, 3'b010, 32'h100, 32'h0);
      chk("lw_araddr", ar_addr, 32'h100);
      chk("lw_arvalid_cyc", 32'(ar_first), 32'd1);
      chk("lw_rready_cyc", 32'(rr_first), 32'd2);
      chk("lw_latency", 32'(lat), 32'd3);
      chk("lw_load_valid", {31'h0, lv_done}, 32'd1);
      chk("lw_data", load_data, 32'h8899AABB);
      chk("lw_post_lv", {31'h0, post_lv}, 32'd0);

      // byte/half extracts
      rdata_cfg = 32'h80FFFFFF;
      run_op(1'b0, 3'b000, 32'h103, 32'h0);
      chk("lb_araddr", ar_addr, 32'h100);
      chk("lb_data", load_data, 32'hFFFFFF80);
      run_op(1'b0, 3'b100, 32'h103, 32'h0);
      chk("lbu_data", load_data, 32'h00000080);
      rdata_cfg = 32'h1234ABCD;
      run_op(1'b0, 3'b101, 32'h102, 32'h0);
      chk("lhu_data", load_data, 32'h00001234);
      run_op(1'b0, 3'b001, 32'h100, 32'h0);
      chk("lh_data", load_data, 32'hFFFFABCD);

      // SH with AWREADY two cycles behind WREADY
      aw_wait = 2;
      run_op(1'b1, 3'b001, 32'h202, 32'h0000BEEF);
      chk("sh_awaddr", aw_addr, 32'h200);
      chk("sh_wdata", w_data, 32'hBEEF0000);
      chk("sh_wstrb", {28'h0, w_strb}, 32'hC);
      chk("sh_w_hs_cyc", 32'(w_hs), 32'd1);
      chk("sh_aw_hs_cyc", 32'(aw_hs), 32'd3);
      chk("sh_latency", 32'(lat), 32'd5);
      chk("sh_load_valid", {31'h0, lv_done}, 32'd0);
      aw_wait = 0;

      // SB, zero waits
      run_op(1'b1, 3'b000, 32'h201, 32'h000000A5);
      chk("sb_wdata", w_data, 32'h0000A500);
      chk("sb_wstrb", {28'h0, w_strb}, 32'h2);
      chk("sb_latency", 32'(lat), 32'd3);

      // misaligned LW: no bus traffic, no stall
      run_op(1'b0, 3'b010, 32'h101, 32'h0);
      chk("mis_latency", 32'(lat), 32'd0);
      chk("mis_err", {31'h0, mis0}, 32'd1);
      chk("mis_no_ar", 32'(ar_first), 32'hFFFFFFFF);
      chk("mis_post_valid", {31'h0, post_valid}, 32'd0);
      chk("mis_post_lv", {31'h0, post_lv}, 32'd0);

      // error responses
      bresp_cfg = 2'b10;
      run_op(1'b1, 3'b010, 32'h300, 32'hDEADBEEF);
      chk("sw_slverr_bus_err", {31'h0, be_done}, 32'd1);
      chk("sw_slverr_latency", 32'(lat), 32'd3);
      bresp_cfg = 2'b00;
      rresp_cfg = 2'b11; rdata_cfg = 32'h55667788;
      run_op(1'b0, 3'b010, 32'h100, 32'h0);
      chk("lw_decerr_bus_err", {31'h0, be_done}, 32'd1);
      chk("lw_decerr_data", load_data, 32'h0);
      rresp_cfg = 2'b00;

      // reset while waiting in RD_DATA
      r_wait = 4;
      @(posedge ACLK); #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
      begin
         int n;
         n = 0;
         do begin
            @(negedge ACLK);
            n++;
         end while (!axi.RREADY && n < 20);
         chk("rst_reached_rd_data", {31'h0, axi.RREADY}, 32'd1);
      end
      @(posedge ACLK); #1;
      ARESETn = 1'b0; req_valid = 1'b0;
      #1;
      chk("rst_mid_handshakes", {27'h0, axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID,
                                 axi.BREADY}, 32'h0);
      chk("rst_mid_stall", {31'h0, stall_req}, 32'd0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1; r_wait = 0;
      rdata_cfg = 32'h11223344;
      run_op(1'b0, 3'b010, 32'h104, 32'h0);
      chk("after_rst_latency", 32'(lat), 32'd3);
      chk("after_rst_araddr", ar_addr, 32'h104);
      chk("after_rst_data", load_data, 32'h11223344);
      chk("after_rst_lv", {31'h0, lv_done}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
